// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: multiplier FSM encoding
// and the supported multiplier latency range.
package hazard_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MULT = 1'b1
  } state_t;

  localparam int MULT_LAT_MIN = 2;
  localparam int MULT_LAT_MAX = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller: hazard inputs from ID/EX and the
// enable/flush controls back to the PC and pipeline registers.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  ex_is_mult;
  logic                  ex_branch_taken;
  logic                  pc_en;
  logic                  if_id_en;
  logic                  id_ex_en;
  logic                  ex_mem_en;
  logic                  mem_wb_en;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  ex_mem_flush;
  logic                  mult_start;
  logic                  mult_busy;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_is_mult, ex_branch_taken,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, ex_mem_flush, mult_start, mult_busy, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_mem_read, ex_is_mult, ex_branch_taken,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, ex_mem_flush, mult_start, mult_busy, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_mult_seq.sv
// Multi-cycle multiplier sequencer: holds the front of the pipe while a multiply
// occupies EX, releasing it on the final cycle so EX/MEM captures the product.
//
// state | meaning
// IDLE  | no multiply in EX; a multiply seen here launches the sequence
// MULT  | multiply in progress; cnt counts down remaining stall cycles, 0 = done cycle
module mult_seq
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_is_mult,
  output logic mult_start,
  output logic mult_busy,
  output logic mult_stall
);

  localparam int            CW       = $clog2(MULT_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MULT_LAT - 2);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mult_start = 1'b0;
    mult_stall = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (ex_is_mult) begin
            mult_start = 1'b1;
            mult_stall = 1'b1;
            cnt_nxt    = CNT_LOAD;
            state_nxt  = MULT;
          end
        end
        MULT: begin
          // ex_is_mult stays high through the done cycle; it is not a restart
          if (cnt == '0) begin
            state_nxt = IDLE;
          end else begin
            mult_stall = 1'b1;
            cnt_nxt    = cnt - CW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign mult_busy = !rst && ((state == MULT) || mult_start);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: multiply stall, taken-branch squash and load-use
// bubble, prioritised in that order, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_LAT   = 4,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
  localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};

  logic mult_start;
  logic mult_busy;
  logic mult_stall;
  logic load_use;

  mult_seq #(
    .MULT_LAT (MULT_LAT)
  ) u_mult_seq (
    .clk        (clk),
    .rst        (rst),
    .ex_is_mult (bus.ex_is_mult),
    .mult_start (mult_start),
    .mult_busy  (mult_busy),
    .mult_stall (mult_stall)
  );

  assign load_use = bus.ex_mem_read && (bus.ex_rd != ZERO_REG) &&
                    ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));

  assign bus.mult_start = mult_start;
  assign bus.mult_busy  = mult_busy;

  always_comb begin
    bus.pc_en        = 1'b1;
    bus.if_id_en     = 1'b1;
    bus.id_ex_en     = 1'b1;
    bus.ex_mem_en    = 1'b1;
    bus.mem_wb_en    = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_flush = 1'b0;
    if (rst) begin
      bus.pc_en        = 1'b0;
      bus.if_id_en     = 1'b0;
      bus.id_ex_en     = 1'b0;
      bus.ex_mem_en    = 1'b0;
      bus.mem_wb_en    = 1'b0;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_flush = 1'b1;
    end else if (mult_stall) begin
      bus.pc_en        = 1'b0;
      bus.if_id_en     = 1'b0;
      bus.id_ex_en     = 1'b0;
      bus.ex_mem_flush = 1'b1;
    end else if (!mult_busy) begin
      // mult_busy low implies ex_is_mult low, so the branch is never masked here
      if (bus.ex_branch_taken) begin
        bus.if_id_flush = 1'b1;
        bus.id_ex_flush = 1'b1;
      end else if (load_use) begin
        bus.pc_en       = 1'b0;
        bus.if_id_en    = 1'b0;
        bus.id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.stall_cnt <= '0;
    end else if (!bus.pc_en && (bus.stall_cnt != CNT_MAX)) begin
      bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios followed by random traffic,
// every cycle checked against a cycle-age reference model.
module tb_pipe_hazard_ctrl;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(
    .MULT_LAT (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  int     age   = 0;   // cycles the current multiply has already spent in EX
  longint sc    = 0;   // expected stall count
  longint base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, check outputs against the model, advance the model.
  // Control vector: pc, if_id, id_ex, ex_mem, mem_wb enables | if_id, id_ex, ex_mem flushes | start, busy
  task automatic cyc(input logic r, input logic m, input logic ld, input logic br,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    logic [9:0] e;
    bit         lu;
    @(negedge clk);
    rst                 = r;
    bus.ex_is_mult      = m;
    bus.ex_mem_read     = ld;
    bus.ex_branch_taken = br;
    bus.ex_rd           = rd;
    bus.id_rs1          = rs1;
    bus.id_rs2          = rs2;
    #1;
    lu = ld && (rd != 0) && (rd == rs1 || rd == rs2);
    if (r)                          e = 10'b00000_111_00;
    else if (age == 0 && m)         e = 10'b00011_001_11;
    else if (age > 0 && age < LAT-1) e = 10'b00011_001_01;
    else if (age == LAT-1)          e = 10'b11111_000_01;
    else if (br)                    e = 10'b11111_110_00;
    else if (lu)                    e = 10'b00111_010_00;
    else                            e = 10'b11111_000_00;
    chk("ctrl", {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                 bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush,
                 bus.mult_start, bus.mult_busy}, e);
    chk("stall_cnt", bus.stall_cnt, sc);
    if (r) begin
      age = 0;
      sc  = 0;
    end else begin
      if (!e[9] && sc < 64'hFFFF_FFFF) sc++;
      if (age == 0 && m)               age = 1;
      else if (age > 0 && age < LAT-1) age++;
      else                             age = 0;
    end
  endtask

  initial begin
    bus.ex_is_mult      = 1'b0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.ex_rd           = '0;
    bus.id_rs1          = '0;
    bus.id_rs2          = '0;

    // reset held two cycles, then release
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_flush", {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush}, 3'b111);
    chk("rst_en", {bus.pc_en, bus.mem_wb_en}, 2'b00);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst_sc", bus.stall_cnt, 0);
    chk("rel_en", {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en}, 5'b11111);

    // single multiply entering EX at cycle 5
    for (int i = 1; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    base = sc;
    for (int i = 5; i < 5 + LAT; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("mul_start", bus.mult_start, (i == 5));
      chk("mul_pc", bus.pc_en, (i == 5 + LAT - 1));
      chk("mul_flush", bus.ex_mem_flush, (i < 5 + LAT - 1));
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("mul_sc", bus.stall_cnt, base + LAT - 1);

    // back-to-back multiplies
    base = sc;
    for (int i = 0; i < 2 * LAT; i++) begin
      cyc(0, 1, 0, 1, 0, 0, 0);
      chk("b2b_start", bus.mult_start, (i % LAT == 0));
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("b2b_sc", bus.stall_cnt, base + 2 * (LAT - 1));

    // load-use, then the same with x0 as destination
    cyc(0, 0, 1, 0, 7, 3, 7);
    chk("lu_pc", bus.pc_en, 1'b0);
    chk("lu_bubble", bus.id_ex_flush, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lu_release", bus.pc_en, 1'b1);
    cyc(0, 0, 1, 0, 0, 3, 0);
    chk("lu_x0", {bus.pc_en, bus.id_ex_flush}, 2'b10);

    // taken branch together with a load-use match
    base = sc;
    cyc(0, 0, 1, 1, 7, 7, 1);
    chk("br_lu", {bus.pc_en, bus.if_id_flush, bus.id_ex_flush}, 3'b111);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("br_sc", bus.stall_cnt, base);

    // reset on the second stall cycle of a multiply
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rstmul_busy", bus.mult_busy, 1'b0);
    chk("rstmul_en", {bus.pc_en, bus.if_id_en, bus.id_ex_en}, 3'b111);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, m;
      r = ($urandom_range(0, 59) == 0);
      m = (age > 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
      cyc(r, m, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit for the 5-stage core with the 4-cycle multiplier. It drives the enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It sequences the multi-cycle multiplier occupying EX, inserts load-use bubbles and squashes wrong-path instructions on taken branches. It also keeps a saturating stall-cycle performance counter.

## Interface
- `MULT_LAT`, 4, cycles a multiply occupies EX; legal range 2..16.
- `REG_ADDR_W`, 5, register-index width.
- `CNT_W`, 32, stall-counter width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `id_rs1`, `id_rs2`  in  REG_ADDR_W  source registers of the instruction in ID.
- `ex_rd`  in  REG_ADDR_W  destination register of the instruction in EX.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_is_mult`  in  1  instruction in EX is a multiply.
- `ex_branch_taken`  in  1  branch in EX resolved taken.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1  register enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`  out  1  register flushes; flush has priority over enable at the register.
- `mult_start`  out  1  one-cycle pulse that launches the multiplier.
- `mult_busy`  out  1  multiplier sequence in progress.
- `stall_cnt`  out  CNT_W  count of cycles with `pc_en`=0.

## Operation
- State: FSM `IDLE`/`MULT`, a `$clog2(MULT_LAT)`-bit cycle counter `cnt`, and `stall_cnt`. All outputs except `stall_cnt` are combinational from state and inputs.
- Default in IDLE with no event: all enables 1, all flushes 0.
- Multiply, IDLE with `ex_is_mult`=1:
  - Assert `mult_start`=1 and the stall set: `pc_en`=`if_id_en`=`id_ex_en`=0, `ex_mem_flush`=1.
  - Set `cnt`←1 and go to MULT.
- MULT with `cnt`<MULT_LAT-1: assert the stall set, `cnt`++.
- MULT with `cnt`=MULT_LAT-1 (done cycle): all enables 1, no flush, go to IDLE. EX/MEM captures the product.
- `mem_wb_en`=1 always, so older instructions drain during a multiply.
- `ex_is_mult` is still 1 during MULT, including the done cycle. It must not restart the sequence. A back-to-back multiply is seen as a new IDLE start on the following cycle.
- Load-use, IDLE only:
  - Condition: `ex_mem_read` && `ex_rd`≠0 && (`ex_rd`=`id_rs1` || `ex_rd`=`id_rs2`).
  - Response: `pc_en`=`if_id_en`=0, `id_ex_flush`=1 (bubble). One cycle.
- Branch, IDLE, `ex_branch_taken`=1: `if_id_flush`=`id_ex_flush`=1, `pc_en`=1 so the target is loaded.
- Priority: mult sequence > branch > load-use. During MULT, branch and load-use inputs are ignored. `ex_branch_taken` is ignored whenever `ex_is_mult`=1.
- `mult_busy` = (state=MULT) || `mult_start`.
- `stall_cnt` increments every cycle `pc_en`=0 and saturates at 2^CNT_W-1.

## Timing
- Reset:
  - While `rst`=1, outputs are forced: all enables 0; `if_id_flush`=`id_ex_flush`=`ex_mem_flush`=1; `mult_start`=`mult_busy`=0.
  - After reset: state IDLE, `cnt`=0, `stall_cnt`=0.
- Reset mid-multiply abandons the sequence: IDLE and `mult_busy`=0 on the first cycle after `rst` falls. No `mult_start` unless `ex_is_mult`=1 in that cycle.
- Multiply latency, for a multiply entering EX at cycle t:
  - Stall set asserted at t..t+MULT_LAT-2 (MULT_LAT-1 stall cycles).
  - Release at t+MULT_LAT-1; `stall_cnt` grows by MULT_LAT-1.
- Load-use costs 1 stall cycle. Branch costs 0 stall cycles and 2 squashed slots.
- Load-use and taken branch in the same cycle: branch wins, so no stall and `pc_en`=1.
- Load to `ex_rd`=0 never stalls.

## Structure
- Shared package `hazard_pkg`: state encoding (`IDLE`=0, `MULT`=1) and the `MULT_LAT` legal-range constants.
- One sub-module, `mult_seq`: the FSM plus `cnt`, producing `mult_start`, `mult_busy` and `mult_stall`.
- The top level does hazard detection, priority muxing and `stall_cnt`.

## Test plan
- Reset: hold `rst` 2 cycles → all flushes 1, enables 0, `stall_cnt`=0; first cycle after release → all enables 1.
- Multiply, MULT_LAT=4, `ex_is_mult` from cycle 5:
  - `mult_start` is 1 only at cycle 5; `pc_en`=0 at cycles 5–7, 1 at cycle 8.
  - `ex_mem_flush`=1 at cycles 5–7; `stall_cnt`=3.
- Back-to-back multiplies (`ex_is_mult` held 8 cycles) → `mult_start` pulses at cycles 0 and 4, `stall_cnt`=6.
- Load-use: `ex_mem_read`=1, `ex_rd`=7, `id_rs2`=7 → one cycle with `pc_en`=0 and `id_ex_flush`=1. Same stimulus with `ex_rd`=0 → no stall.
- Taken branch plus simultaneous load-use match → `if_id_flush`=`id_ex_flush`=1, `pc_en`=1, `stall_cnt` unchanged.
- `rst` asserted at the second stall cycle of a multiply → after release: IDLE, `mult_busy`=0, enables 1 with `ex_is_mult`=0.
